// File: rtl/banked_ram_pkg.sv
// rtl/banked_ram_pkg.sv - shared types and helpers for the banked RAM controller.
// Parity helpers are only used when RAM_PARITY_EN is defined.
package banked_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PARITY_MAX_W = 64;

  function automatic int lanes_of(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Zero-extended lanes keep the same even parity, so one wide helper serves any lane width.
  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - one storage bank with per-lane writes and a registered read port.
// RAM_PARITY_EN adds one even-parity bit per lane and a registered parity-error flag.
module ram_bank
  import banked_ram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LANE_W = 8,
  parameter int LANES  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef RAM_PARITY_EN
  input  logic              perr_inject_i,
  output logic              rerr_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (cs_i && we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

  // The read register only loads on a read to this bank, so it holds across back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (cs_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

`ifdef RAM_PARITY_EN
  logic [LANES-1:0]        par_mem_q [DEPTH];
  logic [LANES-1:0]        wpar;
  logic [LANES-1:0]        rd_mismatch;
  logic [PARITY_MAX_W-1:0] ext;
  logic                    rerr_q;

  always_comb begin
    wpar        = '0;
    rd_mismatch = '0;
    ext         = '0;
    for (int i = 0; i < LANES; i++) begin
      ext                = '0;
      ext[LANE_W-1:0]    = wdata_i[i*LANE_W +: LANE_W];
      wpar[i]            = parity_of(ext) ^ perr_inject_i;
      ext                = '0;
      ext[LANE_W-1:0]    = mem_q[addr_i][i*LANE_W +: LANE_W];
      rd_mismatch[i]     = parity_of(ext) ^ par_mem_q[addr_i][i];
    end
  end

  always_ff @(posedge clk) begin
    if (cs_i && we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) par_mem_q[addr_i][i] <= wpar[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rerr_q <= 1'b0;
    end else if (cs_i && !we_i) begin
      rerr_q <= |rd_mismatch;
    end
  end

  assign rerr_o = rerr_q;
`endif

endmodule

// File: rtl/banked_sync_ram_ctrl.sv
// rtl/banked_sync_ram_ctrl.sv - banked RAM behind a valid/ready request port and a one-entry response buffer.
// Define RAM_PARITY_EN to add per-lane parity, the req_perr_inject port and a live rsp_err.
module banked_sync_ram_ctrl
  import banked_ram_pkg::*;
#(
  parameter  int NUM_BANKS       = 4,
  parameter  int BANK_ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH      = 16,
  parameter  int LANE_WIDTH      = 8,
  localparam int LANES           = lanes_of(DATA_WIDTH, LANE_WIDTH),
  localparam int BANK_SEL_WIDTH  = $clog2(NUM_BANKS),
  localparam int ADDR_WIDTH      = BANK_SEL_WIDTH + BANK_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_be,
`ifdef RAM_PARITY_EN
  input  logic                  req_perr_inject,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam logic [BANK_ADDR_WIDTH-1:0] ROW_ONE = {{(BANK_ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                       init_done_q, init_done_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [BANK_SEL_WIDTH-1:0]  bank_sel_q, bank_sel_d;

  logic                       accept;
  logic [BANK_SEL_WIDTH-1:0]  req_bank;
  logic [NUM_BANKS-1:0]       bank_cs;
  logic                       mem_we;
  logic [LANES-1:0]           mem_be;
  logic [BANK_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [DATA_WIDTH-1:0]      bank_rdata [NUM_BANKS];

  assign req_bank = req_addr[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rsp_valid_d = rsp_valid_q;
    bank_sel_d  = bank_sel_q;
    req_ready   = 1'b0;
    accept      = 1'b0;
    bank_cs     = '0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = req_addr[BANK_ADDR_WIDTH-1:0];
    mem_wdata   = req_wdata;
    case (state_q)
      INIT: begin
        // Zero one row in every bank and lane per cycle.
        bank_cs   = '1;
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ROW_ONE;
        if (cnt_q == '1) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        req_ready = !rsp_valid_q || rsp_ready;
        accept    = req_valid && req_ready;
        mem_we    = req_we;
        mem_be    = req_be;
        if (accept) bank_cs[req_bank] = 1'b1;
        if (accept && !req_we) begin
          rsp_valid_d = 1'b1;
          bank_sel_d  = req_bank;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      bank_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      bank_sel_q  <= bank_sel_d;
    end
  end

`ifdef RAM_PARITY_EN
  logic                 mem_inject;
  logic [NUM_BANKS-1:0] bank_rerr;
  assign mem_inject = (state_q == RUN) && req_perr_inject;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_bank #(
      .ADDR_W (BANK_ADDR_WIDTH),
      .DATA_W (DATA_WIDTH),
      .LANE_W (LANE_WIDTH),
      .LANES  (LANES)
    ) u_bank (
      .clk           (clk),
      .rst_n         (rst_n),
      .cs_i          (bank_cs[b]),
      .we_i          (mem_we),
      .be_i          (mem_be),
      .addr_i        (mem_addr),
      .wdata_i       (mem_wdata),
`ifdef RAM_PARITY_EN
      .perr_inject_i (mem_inject),
      .rerr_o        (bank_rerr[b]),
`endif
      .rdata_o       (bank_rdata[b])
    );
  end

  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;
  assign rsp_rdata = bank_rdata[bank_sel_q];
`ifdef RAM_PARITY_EN
  assign rsp_err   = bank_rerr[bank_sel_q];
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_banked_sync_ram_ctrl.sv
// tb/tb_banked_sync_ram_ctrl.sv - scoreboard bench for banked_sync_ram_ctrl (RAM_PARITY_EN aware).
module tb_banked_sync_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
`ifdef RAM_PARITY_EN
  logic        req_perr_inject;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int          n_checks;
  int          n_fail;
  logic [16:0] exp_q[$];

  banked_sync_ram_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_be          (req_be),
`ifdef RAM_PARITY_EN
    .req_perr_inject (req_perr_inject),
`endif
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .init_done       (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [13:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input logic inj, input logic [16:0] exp);
    bit ok;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
`ifdef RAM_PARITY_EN
    req_perr_inject = inj;
`else
    if (inj) $display("note: inject ignored without parity");
`endif
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        if (!we) exp_q.push_back(exp);
      end
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
`ifdef RAM_PARITY_EN
    req_perr_inject = 1'b0;
`endif
    if (!ok) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] wd, input logic [1:0] be);
    issue(1'b1, addr, wd, be, 1'b0, 17'h0);
  endtask

  task automatic rd(input logic [13:0] addr, input logic [15:0] exp_d, input logic exp_e);
    issue(1'b0, addr, 16'h0, 2'b00, 1'b0, {exp_e, exp_d});
  endtask

  task automatic wait_init();
    int cycles;
    cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (init_done) break;
    end
    check("init_cycles", cycles, 32'd4096);
    check("init_done", init_done, 1);
    check("init_req_ready", req_ready, 1);
  endtask

  // Monitor: a response is consumed on an edge where rsp_valid && rsp_ready.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[15:0]);
          check("rsp_err", rsp_err, e[16]);
        end
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
`ifdef RAM_PARITY_EN
    req_perr_inject = 1'b0;
`endif
    rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();

    rd(14'h0003, 16'h0000, 1'b0);
    wr(14'h1005, 16'hBEEF, 2'b11);
    rd(14'h1005, 16'hBEEF, 1'b0);
    check("read_latency_valid", rsp_valid, 1);
    rd(14'h0005, 16'h0000, 1'b0);
    rd(14'h2005, 16'h0000, 1'b0);
    rd(14'h3005, 16'h0000, 1'b0);

    wr(14'h1005, 16'h1234, 2'b01);
    rd(14'h1005, 16'hBE34, 1'b0);
    wr(14'h1005, 16'hFFFF, 2'b00);
    rd(14'h1005, 16'hBE34, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd(14'h1005, 16'hBE34, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 16'hBE34);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    rd(14'h0005, 16'h0000, 1'b0);
    check("nobubble_valid", rsp_valid, 1);
    check("nobubble_rdata", rsp_rdata, 16'h0000);
    rd(14'h1005, 16'hBE34, 1'b0);
    @(posedge clk);
    #1;
    check("drain_valid_low", rsp_valid, 0);
    check("drain_rdata_hold", rsp_rdata, 16'hBE34);

    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rd(14'h1005, 16'hBE34, 1'b0);
    check("midrst_pending", rsp_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_init_done", init_done, 0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init();
    rd(14'h1005, 16'h0000, 1'b0);

`ifdef RAM_PARITY_EN
    issue(1'b1, 14'h0001, 16'h00FF, 2'b01, 1'b1, 17'h0);
    rd(14'h0001, 16'h00FF, 1'b1);
    wr(14'h0001, 16'h00FF, 2'b01);
    rd(14'h0001, 16'h00FF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
